// File: rtl/inst_fetch_queue_pkg.sv
// Shared opcodes, opcode field position and fetch FSM encodings for the
// instruction fetch front end.
package inst_fetch_queue_pkg;

    localparam int OPTYPE_RANGE_HI = 6;
    localparam int OPTYPE_RANGE_LO = 0;

    localparam logic [OPTYPE_RANGE_HI:OPTYPE_RANGE_LO] OP_JAL = 7'b1101111;
    localparam logic [OPTYPE_RANGE_HI:OPTYPE_RANGE_LO] OP_BR  = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Decoder-side pop handshake and queue-head fields of the fetch queue.
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int QDEPTH = 4
);
    logic                      dc_to_if_ready;
    logic                      if_to_dc_valid;
    logic [INST_W-1:0]         if_to_dc_inst;
    logic [ADDR_W-1:0]         if_to_dc_PC;
    logic                      if_to_dc_pred_br;
    logic [$clog2(QDEPTH):0]   if_to_dc_count;

    modport master (
        input  dc_to_if_ready,
        output if_to_dc_valid,
        output if_to_dc_inst,
        output if_to_dc_PC,
        output if_to_dc_pred_br,
        output if_to_dc_count
    );

    modport slave (
        output dc_to_if_ready,
        input  if_to_dc_valid,
        input  if_to_dc_inst,
        input  if_to_dc_PC,
        input  if_to_dc_pred_br,
        input  if_to_dc_count
    );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Circular fetch queue with push/pop/flush; payload storage is not reset,
// only pointers and occupancy are.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: I-cache lookup, memory miss handling with fill,
// static next-PC prediction and a small queue towards the decoder.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               clr_in,
    input  logic [ADDR_W-1:0]  rob_to_if_alter_pc,
    output logic [ADDR_W-1:0]  if_to_ic_addr,
    input  logic               ic_to_if_hit,
    input  logic [INST_W-1:0]  ic_to_if_hit_inst,
    output logic               if_to_ic_fill_valid,
    output logic [ADDR_W-1:0]  if_to_ic_fill_addr,
    output logic [INST_W-1:0]  if_to_ic_fill_inst,
    output logic               if_to_mc_valid,
    output logic [ADDR_W-1:0]  if_to_mc_pc,
    input  logic               mc_to_if_ready,
    input  logic [INST_W-1:0]  mc_to_if_inst,
    input  logic               pr_to_if_prediction,
    inst_fetch_queue_if.master dc
);
    localparam int CNT_W   = $clog2(QDEPTH) + 1;
    localparam int ENTRY_W = INST_W + ADDR_W + 1;

    fetch_state_t                        state;
    logic [ADDR_W-1:0]                   pc;
    logic [INST_W-1:0]                   enq_inst;
    logic [OPTYPE_RANGE_HI:OPTYPE_RANGE_LO] opcode;
    logic                                is_jal;
    logic                                is_br;
    logic signed [20:0]                  j_imm;
    logic signed [12:0]                  b_imm;
    logic [ADDR_W-1:0]                   next_pc;
    logic                                enq_pred;
    logic                                enq_fire;
    logic                                push;
    logic                                pop;
    logic                                flush;
    logic                                full;
    logic [CNT_W-1:0]                    count;
    logic [ENTRY_W-1:0]                  head;

    assign if_to_ic_addr = pc;

    // Decode straight from whichever instruction is being enqueued this cycle.
    assign enq_inst = (state == MEM_WAIT) ? mc_to_if_inst : ic_to_if_hit_inst;
    assign opcode   = enq_inst[OPTYPE_RANGE_HI:OPTYPE_RANGE_LO];
    assign is_jal   = (opcode == OP_JAL);
    assign is_br    = (opcode == OP_BR);
    assign j_imm    = {enq_inst[31], enq_inst[19:12], enq_inst[20], enq_inst[30:21], 1'b0};
    assign b_imm    = {enq_inst[31], enq_inst[7], enq_inst[30:25], enq_inst[11:8], 1'b0};
    assign enq_pred = is_br && pr_to_if_prediction;

    always_comb begin
        next_pc = pc + ADDR_W'(32'd4);
        if (is_jal)
            next_pc = pc + ADDR_W'(j_imm);
        else if (enq_pred)
            next_pc = pc + ADDR_W'(b_imm);
    end

    assign enq_fire = ((state == IDLE) && ic_to_if_hit) ||
                      ((state == MEM_WAIT) && mc_to_if_ready);
    assign push     = rdy_in && !clr_in && !full && enq_fire;
    assign pop      = rdy_in && dc.if_to_dc_valid && dc.dc_to_if_ready;
    assign flush    = rdy_in && clr_in;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wdata    ({enq_inst, pc, enq_pred}),
        .rdata    (head),
        .full     (full),
        .count    (count)
    );

    assign dc.if_to_dc_valid = (count != '0);
    assign dc.if_to_dc_count = count;
    assign {dc.if_to_dc_inst, dc.if_to_dc_PC, dc.if_to_dc_pred_br} = head;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state               <= IDLE;
            pc                  <= RESET_PC;
            if_to_mc_valid      <= 1'b0;
            if_to_mc_pc         <= '0;
            if_to_ic_fill_valid <= 1'b0;
            if_to_ic_fill_addr  <= '0;
            if_to_ic_fill_inst  <= '0;
        end else if (rdy_in) begin
            if_to_ic_fill_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_in) begin
                        pc <= rob_to_if_alter_pc;
                    end else if (!full) begin
                        if (ic_to_if_hit) begin
                            pc <= next_pc;
                        end else begin
                            if_to_mc_valid <= 1'b1;
                            if_to_mc_pc    <= pc;
                            state          <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (clr_in) begin
                        pc <= rob_to_if_alter_pc;
                        if (mc_to_if_ready) begin
                            if_to_mc_valid <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            // Request stays outstanding; its response is dropped.
                            state <= DRAIN;
                        end
                    end else if (mc_to_if_ready) begin
                        if_to_mc_valid      <= 1'b0;
                        if_to_ic_fill_valid <= 1'b1;
                        if_to_ic_fill_addr  <= pc;
                        if_to_ic_fill_inst  <= mc_to_if_inst;
                        pc                  <= next_pc;
                        state               <= IDLE;
                    end
                end
                DRAIN: begin
                    if (clr_in) pc <= rob_to_if_alter_pc;
                    if (mc_to_if_ready) begin
                        if_to_mc_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC and address width.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning fetch-queue entries; power of 2, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the PC after reset.
REQ-005 SHALL have port clk_in  input  1  the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port rdy_in  input  1  global enable; when low, all state is frozen.
REQ-008 SHALL have port clr_in  input  1  redirect or flush request from the ROB.
REQ-009 SHALL have port rob_to_if_alter_pc  input  ADDR_W  redirect target.
REQ-010 SHALL have port if_to_ic_addr  output  ADDR_W  lookup address, driven combinationally equal to the current PC.
REQ-011 SHALL have port ic_to_if_hit  input  1  the I-cache hit for if_to_ic_addr in the same cycle.
REQ-012 SHALL have port ic_to_if_hit_inst  input  INST_W  the hit instruction.
REQ-013 SHALL have ports if_to_ic_fill_valid (output, 1), if_to_ic_fill_addr (output, ADDR_W) and if_to_ic_fill_inst (output, INST_W), forming a one-cycle I-cache fill pulse.
REQ-014 SHALL have ports if_to_mc_valid (output, 1) and if_to_mc_pc (output, ADDR_W), forming the memory fetch request.
REQ-015 SHALL have ports mc_to_if_ready (input, 1, one-cycle pulse) and mc_to_if_inst (input, INST_W), forming the memory fetch response.
REQ-016 SHALL have port pr_to_if_prediction  input  1  taken prediction for the current PC.
REQ-017 SHALL have ports dc_to_if_ready (input, 1) and if_to_dc_valid (output, 1), forming the decoder pop handshake.
REQ-018 SHALL have ports if_to_dc_inst (INST_W), if_to_dc_PC (ADDR_W) and if_to_dc_pred_br (1), all outputs, carrying the queue-head fields.
REQ-019 SHALL have port if_to_dc_count  output  $clog2(QDEPTH)+1  queue occupancy.

Function
REQ-020 SHALL implement an FSM with states IDLE, MEM_WAIT and DRAIN.
REQ-021 SHALL, in IDLE with the queue not full and ic_to_if_hit=1, enqueue {hit_inst, PC, pred} and set PC<=nextPC in that edge.
REQ-022 SHALL, in IDLE with the queue not full and no hit, set if_to_mc_valid=1 with if_to_mc_pc=PC and go to MEM_WAIT.
REQ-023 SHALL hold if_to_mc_valid and if_to_mc_pc stable until mc_to_if_ready is seen.
REQ-024 SHALL, in MEM_WAIT on mc_to_if_ready, enqueue {mc_to_if_inst, PC, pred}, pulse the fill with addr=PC and inst=mc_to_if_inst, drop if_to_mc_valid, set PC<=nextPC and return to IDLE.
REQ-025 SHALL compute nextPC as: opcode 1101111 (JAL) gives PC+sext(J-imm); opcode 1100011 with prediction=1 gives PC+sext(B-imm); otherwise PC+4; all modulo 2^ADDR_W.
REQ-026 SHALL decode nextPC from the instruction actually being enqueued (the hit or memory instruction), not from a registered copy.
REQ-027 SHALL set pred to pr_to_if_prediction for branches and 0 for all other instructions.
REQ-028 SHALL fetch nothing and hold PC when the queue is full; an enqueue and a dequeue in the same cycle while full SHALL NOT enqueue.
REQ-029 SHALL make if_to_dc_valid equal to count!=0, with the head fields driven combinationally from the read pointer.
REQ-030 SHALL pop when valid && dc_to_if_ready.
REQ-031 SHALL leave count unchanged on a simultaneous push and pop when the queue is not full.
REQ-032 SHALL wrap the read and write pointers modulo QDEPTH.
REQ-033 SHALL give clr_in priority over all other events: empty the queue (count=0, pointers=0), set PC<=rob_to_if_alter_pc, and suppress any push or fill in that cycle.
REQ-034 SHALL, on clr_in in MEM_WAIT before the response arrives, keep if_to_mc_valid high and go to DRAIN.
REQ-035 SHALL, in DRAIN, discard the response and issue no fill on mc_to_if_ready, then go to IDLE.
REQ-036 SHALL, on clr_in in the same cycle as mc_to_if_ready, discard the response and go to IDLE.
REQ-037 SHALL, when rdy_in=0, change no state; registered outputs hold and the pop handshake is ignored.
REQ-038 SHALL have a latency of 1 cycle from an I-cache hit to if_to_dc_valid, and 1 cycle from mc_to_if_ready to if_to_dc_valid.

Reset
REQ-039 SHALL, on rst_n_in low, asynchronously set: PC=RESET_PC; state=IDLE; count=0; pointers=0; if_to_mc_valid=0; if_to_ic_fill_valid=0; if_to_mc_pc=0; fill address and instruction=0.
REQ-040 SHALL, during reset, drive if_to_dc_valid=0 and if_to_dc_count=0.
REQ-041 SHALL leave queue payload storage unreset.
REQ-042 SHALL, on reset asserted mid-request, abandon the request, and the memory controller SHALL be reset by the same rst_n_in.

Structure
REQ-043 SHALL import OP_JAL, OP_BR, the OPTYPE_RANGE opcode range and the fetch FSM state encodings from the shared package.
REQ-044 SHALL place the queue in one sub-module, fetch_fifo, parametrised by width and depth, providing push, pop, flush, full and count.
REQ-045 SHALL place the immediate-decode and nextPC logic inside inst_fetch_queue as combinational logic.

Verification
REQ-046 SHALL cover: reset, then the I-cache hits every cycle with addi at PC 0,4,8 and dc_ready=1 -> if_to_dc_PC 0,4,8 on consecutive cycles, count no higher than 1.
REQ-047 SHALL cover: a miss at PC 0x10, then mc_ready 5 cycles later with 0x00000013 -> one fill pulse with addr 0x10, a queue entry at PC 0x10, and a next fetch at 0x14.
REQ-048 SHALL cover: JAL with +0x20 at PC 0x100 -> next fetch at 0x120; BEQ with -8 at 0x200 and pred=1 -> next fetch at 0x1F8 with pred_br=1.
REQ-049 SHALL cover: QDEPTH=4, dc_ready=0, continuous hits -> count reaches 4, PC holds, and no further pushes occur until a pop.
REQ-050 SHALL cover: clr_in to 0x400 while in MEM_WAIT, then the response -> no fill or push, queue empty, next request at 0x400.
REQ-051 SHALL cover: rst_n_in low mid-request -> if_to_mc_valid=0, if_to_dc_valid=0, PC=RESET_PC immediately, before the next clock edge.
